tlc_phase_arbiter: RTL and testbench

TLC_PHASE_ARBITER -- requirements
Module: tlc_phase_arbiter

---
 rtl/tlc_pkg.sv | 32 +++
 rtl/rr_pick4.sv | 26 ++
 rtl/tlc_phase_arbiter.sv | 129 ++++++++++++
 tb/tb_tlc_phase_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the four-approach traffic-light phase arbiter:
// light codes, approach indices, FSM states and small encoding helpers.
package tlc_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [1:0] M1 = 2'd0;
  localparam logic [1:0] M2 = 2'd1;
  localparam logic [1:0] MT = 2'd2;
  localparam logic [1:0] S  = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Packed {S, MT, M2, M1} light vector: one approach shows col, the rest red.
  function automatic logic [11:0] light_vec(input logic [1:0] idx, input logic [2:0] col);
    logic [11:0] v;
    v = {4{RED}};
    v[int'(idx) * 3 +: 3] = col;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four pending requests, searching
// last+1, last+2, last+3, last (mod 4).
module rr_pick4
  import tlc_pkg::*;
(
  input  logic [3:0] i_pend,
  input  logic [1:0] i_last,
  output logic [1:0] o_grant,
  output logic       o_any
);

  logic [1:0] w_idx;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 4; k >= 1; k--) begin
      w_idx = i_last + 2'(k);
      if (i_pend[w_idx]) o_grant = w_idx;
    end
  end

  assign o_any = |i_pend;

endmodule

// File: rtl/tlc_phase_arbiter.sv
// Four-approach traffic-light phase arbiter: latched requests, round-robin
// grant, min/max green, fixed yellow and all-red clearance, rest-in-red/green.
module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 7,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [1:0] phase,
  output logic       phase_valid
);

  localparam logic [8:0] MIN_CYC    = 9'(MIN_GREEN);
  localparam logic [8:0] MAX_CYC    = 9'(MAX_GREEN);
  localparam logic [8:0] YELLOW_CYC = 9'(YELLOW_T);
  localparam logic [8:0] ALLRED_CYC = 9'(ALLRED_T);

  state_t      r_state;
  logic [7:0]  r_timer;
  logic [3:0]  r_pend;
  logic [1:0]  r_last;
  logic [1:0]  r_phase;
  logic        r_valid;
  logic [11:0] r_lights;

  logic [1:0]  w_grant;
  logic        w_any;
  logic [8:0]  w_elapsed;
  logic [7:0]  w_timer_inc;
  logic [3:0]  w_others;
  logic [3:0]  w_pend_set;
  logic [3:0]  w_pend_clr;
  logic        w_enter_green;
  logic        w_leave_green;
  logic        w_yellow_done;

  rr_pick4 u_pick (
    .i_pend  (r_pend),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Timer compares are done on cycles-in-state (timer+1) against the raw
  // parameters, which keeps the thresholds meaningful for a value of 1.
  assign w_elapsed   = {1'b0, r_timer} + 9'd1;
  assign w_timer_inc = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
  assign w_others    = r_pend & ~onehot4(r_phase);

  assign w_enter_green = (r_state == ST_CLEAR) && (w_elapsed >= ALLRED_CYC) && w_any;
  assign w_leave_green = (r_state == ST_GREEN) && (w_elapsed >= MIN_CYC) && (|w_others)
                         && (!req[r_phase] || (w_elapsed >= MAX_CYC));
  assign w_yellow_done = (r_state == ST_YELLOW) && (w_elapsed >= YELLOW_CYC);

  assign w_pend_set = req & ~((r_state == ST_GREEN) ? onehot4(r_phase) : 4'b0000);
  assign w_pend_clr = w_enter_green ? onehot4(w_grant) : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_CLEAR;
      r_timer  <= '0;
      r_last   <= S;
      r_phase  <= M1;
      r_valid  <= 1'b0;
      r_lights <= {4{RED}};
    end else begin
      r_timer <= w_timer_inc;
      unique case (r_state)
        ST_CLEAR: begin
          if (w_enter_green) begin
            r_state  <= ST_GREEN;
            r_timer  <= '0;
            r_last   <= w_grant;
            r_phase  <= w_grant;
            r_valid  <= 1'b1;
            r_lights <= light_vec(w_grant, GREEN);
          end
        end
        ST_GREEN: begin
          if (w_leave_green) begin
            r_state  <= ST_YELLOW;
            r_timer  <= '0;
            r_lights <= light_vec(r_phase, YELLOW);
          end
        end
        ST_YELLOW: begin
          if (w_yellow_done) begin
            r_state  <= ST_CLEAR;
            r_timer  <= '0;
            r_valid  <= 1'b0;
            r_lights <= {4{RED}};
          end
        end
        default: begin
          r_state  <= ST_CLEAR;
          r_timer  <= '0;
          r_valid  <= 1'b0;
          r_lights <= {4{RED}};
        end
      endcase
    end
  end

  // A grant edge clears its own bit even if req is still high on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | w_pend_set) & ~w_pend_clr;
    end
  end

  assign light_M1    = r_lights[2:0];
  assign light_M2    = r_lights[5:3];
  assign light_MT    = r_lights[8:6];
  assign light_S     = r_lights[11:9];
  assign phase       = r_phase;
  assign phase_valid = r_valid;

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Directed and randomized bench for tlc_phase_arbiter against a
// rule-level reference model of the traffic phases.
module tb_tlc_phase_arbiter;

  localparam int MIN_G = 7;
  localparam int MAX_G = 20;
  localparam int YEL   = 3;
  localparam int ALLR  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [2:0] light_M1, light_M2, light_MT, light_S;
  logic [1:0] phase;
  logic       phase_valid;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=all red, 1=green, 2=yellow.
  int m_mode;
  int m_age;
  bit m_pend [4];
  int m_last;
  int m_cur;

  tlc_phase_arbiter #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW_T  (YEL),
    .ALLRED_T  (ALLR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .phase       (phase),
    .phase_valid (phase_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_age  = 0;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    m_last = 3;
    m_cur  = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r);
    int old_mode = m_mode;
    int old_cur  = m_cur;
    bit enter    = 1'b0;
    bit others   = 1'b0;
    int g        = 0;
    case (m_mode)
      0: begin
        if (m_age >= ALLR - 1)
          for (int k = 1; k <= 4; k++)
            if (!enter && m_pend[(m_last + k) % 4]) begin
              g = (m_last + k) % 4;
              enter = 1'b1;
            end
        if (enter) begin
          m_mode = 1; m_cur = g; m_last = g; m_age = 0;
        end else m_age++;
      end
      1: begin
        for (int j = 0; j < 4; j++) if (j != m_cur && m_pend[j]) others = 1'b1;
        if (m_age >= MIN_G - 1 && others && (!r[m_cur] || m_age >= MAX_G - 1)) begin
          m_mode = 2; m_age = 0;
        end else m_age++;
      end
      default: begin
        if (m_age >= YEL - 1) begin
          m_mode = 0; m_age = 0;
        end else m_age++;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !(old_mode == 1 && i == old_cur)) m_pend[i] = 1'b1;
      if (enter && i == g) m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [11:0] exp_lights();
    logic [11:0] v = 12'h924;
    if (m_mode != 0) v[m_cur * 3 +: 3] = (m_mode == 1) ? 3'b001 : 3'b010;
    return v;
  endfunction

  task automatic check_model();
    int nonred = 0;
    chk("lights", {light_S, light_MT, light_M2, light_M1}, exp_lights());
    chk("phase_valid", phase_valid, (m_mode != 0));
    if (m_mode != 0) chk("phase", phase, m_cur);
    if (light_M1 !== 3'b100) nonred++;
    if (light_M2 !== 3'b100) nonred++;
    if (light_MT !== 3'b100) nonred++;
    if (light_S  !== 3'b100) nonred++;
    chk("exclusive", (nonred <= 1), 1'b1);
  endtask

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_lights", {light_S, light_MT, light_M2, light_M1}, 12'h924);
    chk("rst_valid", phase_valid, 1'b0);
    chk("rst_phase", phase, 2'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int first;
    bit prevv;
    logic [3:0] r;
    int q[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    model_reset();
    async_reset();

    // Idle after reset: all red for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      cyc(4'b0000);
      chk("idle_lights", {light_S, light_MT, light_M2, light_M1}, 12'h924);
      chk("idle_valid", phase_valid, 1'b0);
    end

    // Single MT pulse: green two edges later, then rest-in-green.
    cyc(4'b0100);
    cyc(4'b0000);
    chk("mt_green", light_MT, 3'b001);
    chk("mt_phase", phase, 2'd2);
    for (int i = 0; i < 40; i++) cyc(4'b0000);
    chk("mt_rest_green", light_MT, 3'b001);

    // M1 green with req[0] held, S asserted: max green then yellow/clear/S.
    n = 0;
    while (light_M1 !== 3'b001 && n < 100) begin n++; cyc(4'b0001); end
    chk("wait_m1", light_M1, 3'b001);
    n = 0;
    while (light_M1 === 3'b001 && n < 60) begin n++; cyc(4'b1001); end
    chk("m1_max_green", n, 20);
    n = 0;
    while (light_M1 === 3'b010 && n < 20) begin n++; cyc(4'b1001); end
    chk("m1_yellow", n, 3);
    n = 0;
    while (phase_valid === 1'b0 && n < 20) begin n++; cyc(4'b1001); end
    chk("allred", n, 1);
    chk("s_green", light_S, 3'b001);

    // M1 green with req[0] low, M2 asserted at green cycle 2: min green.
    n = 0;
    while (light_M1 !== 3'b001 && n < 100) begin n++; cyc(4'b0000); end
    chk("wait_m1_b", light_M1, 3'b001);
    n = 0;
    while (light_M1 === 3'b001 && n < 60) begin
      n++;
      cyc((n >= 3) ? 4'b0010 : 4'b0000);
    end
    chk("m1_min_green", n, 7);
    n = 0;
    while (light_M2 !== 3'b001 && n < 100) begin n++; cyc(4'b0010); end
    chk("m2_next", light_M2, 3'b001);
    chk("m2_phase", phase, 2'd1);

    // From idle with all requests held: round-robin order and grant latency.
    async_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0000);
    n = 0; first = -1; prevv = 1'b0;
    while (q.size() < 5 && n < 400) begin
      n++;
      cyc(4'b1111);
      if (phase_valid === 1'b1 && !prevv) begin
        q.push_back(int'(phase));
        if (first < 0) first = n;
      end
      prevv = phase_valid;
    end
    chk("first_latency", first, 2);
    chk("order_count", q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < q.size()) ? q[i] : 16'hFFFF, exp_order[i]);

    // Reset during MT yellow clears lights and pending requests.
    n = 0;
    while (!(phase === 2'd2 && light_MT === 3'b010) && n < 200) begin n++; cyc(4'b1111); end
    chk("reach_mt_yellow", light_MT, 3'b010);
    async_reset();
    for (int i = 0; i < 20; i++) cyc(4'b0000);
    chk("pend_empty", phase_valid, 1'b0);

    // Randomized traffic against the model, with one mid-run reset.
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      cyc(r);
      if (i == 300) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
